// File: rtl/cpu_req_queue.sv
// CPU request queue: FIFO of CPU read/write requests issued in order to the cache,
// with a cap on outstanding reads and 1-cycle registered read-response return.
package cpu_req_queue_pkg;
  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [19:0] addr;
    logic [31:0] data;
  } cpu_to_cache_type;

  typedef struct packed {
    logic        stopped;
    logic        ready;
    logic [31:0] data;
  } cache_to_cpu_type;
endpackage

module cpu_req_queue
  import cpu_req_queue_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int MAX_RD = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic             req_rw,
  input  logic [19:0]      req_addr,
  input  logic [31:0]      req_data,
  output logic             req_ready,
  output cpu_to_cache_type cpu_to_cache,
  input  cache_to_cpu_type cache_to_cpu,
  output logic             rsp_valid,
  output logic [31:0]      rsp_data,
  output logic [3:0]       rd_pending,
  output logic             err_unexp
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic        rw;
    logic [19:0] addr;
    logic [31:0] data;
  } entry_t;

  entry_t        r_mem [DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [3:0]    r_rd_pending;
  logic          r_rsp_valid;
  logic [31:0]   r_rsp_data;
  logic          r_err_unexp;

  entry_t w_head;
  logic   w_issue, w_push, w_pop, w_rd_pop, w_rsp, w_unexp;

  assign w_head = r_mem[r_rptr];

  // rst gating keeps ready/valid low while held in reset; count alone would read as empty.
  assign req_ready = rst && (r_count < (AW+1)'(DEPTH));
  assign w_issue   = rst && (r_count != '0) && !(!w_head.rw && r_rd_pending == 4'(MAX_RD));
  assign w_push    = req_valid && req_ready;
  assign w_pop     = w_issue && !cache_to_cpu.stopped;
  assign w_rd_pop  = w_pop && !w_head.rw;
  assign w_rsp     = cache_to_cpu.ready && (r_rd_pending != '0);
  assign w_unexp   = cache_to_cpu.ready && (r_rd_pending == '0);

  always_comb begin
    cpu_to_cache = '0;
    if (w_issue) begin
      cpu_to_cache.valid = 1'b1;
      cpu_to_cache.rw    = w_head.rw;
      cpu_to_cache.addr  = w_head.addr;
      cpu_to_cache.data  = w_head.data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {req_rw, req_addr, req_data};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_count      <= '0;
      r_rd_pending <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_err_unexp  <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
      case ({w_rd_pop, w_rsp})
        2'b10:   r_rd_pending <= r_rd_pending + 1'b1;
        2'b01:   r_rd_pending <= r_rd_pending - 1'b1;
        default: ;
      endcase
      r_rsp_valid <= w_rsp;
      if (w_rsp)   r_rsp_data  <= cache_to_cpu.data;
      if (w_unexp) r_err_unexp <= 1'b1;
    end
  end

  assign rd_pending = r_rd_pending;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_data   = r_rsp_data;
  assign err_unexp  = r_err_unexp;
endmodule

// File: tb/tb_cpu_req_queue.sv
// Directed bench for cpu_req_queue: a reference queue of accepted requests and a
// read-data scoreboard are compared against the DUT every cycle.
module tb_cpu_req_queue;
  import cpu_req_queue_pkg::*;
  localparam int DEPTH  = 4;
  localparam int MAX_RD = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_rw = 1'b0;
  logic [19:0]      req_addr = '0;
  logic [31:0]      req_data = '0;
  logic             req_ready;
  cpu_to_cache_type c2c;
  cache_to_cpu_type c2p;
  logic             rsp_valid;
  logic [31:0]      rsp_data;
  logic [3:0]       rd_pending;
  logic             err_unexp;

  cpu_req_queue #(.DEPTH(DEPTH), .MAX_RD(MAX_RD)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_rw(req_rw),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .cpu_to_cache(c2c), .cache_to_cpu(c2p), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .rd_pending(rd_pending), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [19:0] addr;
    logic [31:0] data;
  } req_t;

  req_t        exp_iss[$];   // accepted, not yet issued, in acceptance order
  logic [31:0] exp_rd[$];    // expected read data, in issue order
  logic [19:0] cq[$];        // cache side: addresses of reads it has seen
  int          n_chk = 0, n_err = 0;
  int          m_pend = 0;
  bit          m_due = 1'b0, m_err = 1'b0, auto_cache = 1'b0, last_acc = 1'b0;
  logic [31:0] m_last = '0;

  // Cache contents as a function of address; 0x00100 maps to 0xDEADBEEF.
  function automatic logic [31:0] rdat(logic [19:0] a);
    return 32'hDEADBFEF ^ {12'h0, a};
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Check outputs at the falling edge, advance the model across the rising edge.
  task automatic tick();
    cpu_to_cache_type e;
    bit acc, iss;
    @(negedge clk);
    e = '0;
    if (exp_iss.size() > 0 && !(!exp_iss[0].rw && m_pend == MAX_RD)) begin
      e.valid = 1'b1;
      e.rw    = exp_iss[0].rw;
      e.addr  = exp_iss[0].addr;
      e.data  = exp_iss[0].data;
    end
    chk("cpu_to_cache", 64'(c2c), 64'(e));
    chk("req_ready", 64'(req_ready), 64'(exp_iss.size() < DEPTH));
    chk("rd_pending", 64'(rd_pending), 64'(m_pend));
    chk("rsp", 64'({rsp_valid, rsp_data}), 64'({m_due, m_last}));
    chk("err_unexp", 64'(err_unexp), 64'(m_err));
    acc   = req_valid && exp_iss.size() < DEPTH;
    iss   = e.valid && !c2p.stopped;
    m_due = 1'b0;
    if (c2p.ready) begin
      if (m_pend > 0) begin
        m_due  = 1'b1;
        m_last = (exp_rd.size() > 0) ? exp_rd.pop_front() : 32'hxxxxxxxx;
        m_pend--;
      end else m_err = 1'b1;
    end
    if (iss) begin
      if (!exp_iss[0].rw) begin
        m_pend++;
        exp_rd.push_back(rdat(exp_iss[0].addr));
      end
      void'(exp_iss.pop_front());
    end
    if (c2c.valid && !c2p.stopped && !c2c.rw) cq.push_back(c2c.addr);
    if (acc) exp_iss.push_back('{req_rw, req_addr, req_data});
    last_acc = acc;
    @(posedge clk);
    #1;
    if (auto_cache) begin
      c2p.stopped = ($urandom_range(0, 3) == 0);
      if (cq.size() > 0 && $urandom_range(0, 1) != 0) begin
        c2p.ready = 1'b1;
        c2p.data  = rdat(cq.pop_front());
      end else c2p.ready = 1'b0;
    end
  endtask

  task automatic push(logic rw, logic [19:0] addr, logic [31:0] data);
    req_valid = 1'b1; req_rw = rw; req_addr = addr; req_data = data;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic respond();
    c2p.ready = 1'b1;
    c2p.data  = (cq.size() > 0) ? rdat(cq.pop_front()) : 32'h12345678;
    tick();
    c2p.ready = 1'b0;
  endtask

  task automatic rst_outputs(string tag);
    chk({tag, "_ready"}, 64'(req_ready), 64'(0));
    chk({tag, "_c2c"}, 64'(c2c), 64'(0));
    chk({tag, "_pend"}, 64'(rd_pending), 64'(0));
    chk({tag, "_rsp"}, 64'({rsp_valid, rsp_data}), 64'(0));
    chk({tag, "_err"}, 64'(err_unexp), 64'(0));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    rst_outputs("rst_async");
    exp_iss.delete(); exp_rd.delete(); cq.delete();
    m_pend = 0; m_due = 1'b0; m_err = 1'b0; m_last = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_outputs("rst_held");
    rst = 1'b1;
  endtask

  initial begin
    int n;
    c2p = '0;
    #2;
    do_reset();

    // Fill with stopped cache, 5th push refused, then drain in order.
    c2p.stopped = 1'b1;
    for (int i = 0; i < 5; i++) push(1'b1, 20'h00010 + 20'(4 * i), 32'hA0000000 + 32'(i));
    c2p.stopped = 1'b0;
    repeat (5) tick();

    // Read round trip, response two cycles after issue.
    push(1'b0, 20'h00100, 32'h0);
    tick();
    tick();
    respond();
    repeat (2) tick();

    // Read cap of MAX_RD: third read held until one response returns.
    push(1'b0, 20'h00200, 32'h0);
    push(1'b0, 20'h00204, 32'h0);
    push(1'b0, 20'h00208, 32'h0);
    repeat (2) tick();
    respond();
    tick();
    respond();
    respond();
    repeat (2) tick();

    // Simultaneous push/pop at count 2, then response alongside a read pop.
    c2p.stopped = 1'b1;
    push(1'b1, 20'h00300, 32'h1);
    push(1'b1, 20'h00304, 32'h2);
    c2p.stopped = 1'b0;
    push(1'b1, 20'h00308, 32'h3);
    repeat (3) tick();
    push(1'b0, 20'h00400, 32'h0);
    tick();
    c2p.stopped = 1'b1;
    push(1'b0, 20'h00404, 32'h0);
    c2p.stopped = 1'b0;
    respond();
    tick();
    respond();
    repeat (2) tick();

    // Stream 20 mixed requests with a randomly stalling, randomly answering cache.
    auto_cache = 1'b1;
    n = 0;
    for (int g = 0; g < 400 && n < 20; g++) begin
      req_valid = 1'b1;
      req_rw    = 1'($urandom_range(0, 1));
      req_addr  = 20'h01000 + 20'(4 * n);
      req_data  = $urandom;
      tick();
      if (last_acc) n++;
    end
    req_valid = 1'b0;
    for (int g = 0; g < 200 && (exp_iss.size() > 0 || m_pend > 0 || m_due); g++) tick();
    auto_cache = 1'b0;
    c2p = '0;
    tick();

    // Reset with queued entries and a pending read; late response is unexpected.
    push(1'b0, 20'h00500, 32'h0);
    tick();
    c2p.stopped = 1'b1;
    for (int i = 0; i < 3; i++) push(1'b1, 20'h00600 + 20'(4 * i), 32'(i));
    do_reset();
    c2p.stopped = 1'b0;
    tick();
    respond();
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
